decoder_3to8: RTL and testbench
===============================

Name: decoder_3to8

Overview:
- 3-to-8 line decoder with active-low outputs and 74x138-style enable gating.
- Decode is combinational; the result is captured in an output register, so outputs change on clock edges only.
- Used as a generic select/chip-enable generator in datapath and peripheral-select logic.

Parameters:
- SEL_W, 3, width of the select input; output width is 2**SEL_W. Only the default of 3 is verified.
- RST_OUT, 8'hFF, output value after reset. The default means all outputs are inactive (high).

Ports:
- iClk  input  1  rising-edge clock
- iRst_n  input  1  synchronous reset, active-low
- iData  input  3  binary select code D2..D0 (iData[2] is the MSB)
- iEna  input  2  enables: iEna[1] = G1 (active-high), iEna[0] = G2 (active-low)
- oData  output  8  decoded lines Y7..Y0, active-low, registered

Behaviour:
- Clocking: one clock domain, iClk. The reset is synchronous and active-low.
- Reset: on a rising edge of iClk with iRst_n=0, oData <= 8'hFF. Reset has priority over all other inputs.
- Enable condition: en = iEna[1] & ~iEna[0]. The only enabling combination is iEna = 2'b10.
- Decode when enabled: oData bit iData is 0; every other bit is 1. Equivalent to oData = ~(8'b1 << iData).
- Decode when disabled (iEna = 00, 01 or 11): oData = 8'hFF.
- Latency: exactly 1 cycle. The value of oData after edge N reflects iData and iEna sampled at edge N.
- No internal state besides the output register. No handshake; a new code is accepted every cycle.
- Boundaries:
  - iData=3'b111 gives 8'h7F; iData=3'b000 gives 8'hFE.
  - Enable deasserted mid-stream: on the next edge oData = 8'hFF.
  - Reset asserted mid-operation: on the next edge oData = 8'hFF. The first non-reset edge after release loads the decode of the current inputs.
- X/Z on the inputs is not handled. Do not rely on any specific X behaviour.
- The decoded output never has more than one bit low.

Optional Feature:
- Macro: DECODER_VALID_OUT_EN.
- When defined:
  - Adds output oValid (1 bit, registered, same 1-cycle latency as oData).
  - oValid <= en on each edge; oValid <= 0 during reset.
  - Lets downstream logic tell "disabled" apart from "enabled".
- When undefined: no oValid port, no extra logic. Decoder behaviour is identical in both builds.

Decomposition:
- Package decoder_pkg holds:
  - localparam SEL_W=3 and OUT_W=8
  - localparam OUT_IDLE=8'hFF
  - localparam ENA_ACTIVE=2'b10
- Sub-module decoder_core: purely combinational.
  - Inputs: sel[2:0], en. Output: y_n[7:0].
  - Performs the active-low one-cold decode.
- decoder_3to8 contains the enable logic, instantiates decoder_core, and holds the output register (plus oValid when enabled).

Test Plan:
- Reset: hold iRst_n=0 for 2 edges with iEna=2'b10 and iData=3'b011 -> oData=8'hFF (oValid=0 when the macro is defined).
- Full sweep enabled: iEna=2'b10, iData steps 000..111, 40 ns each -> after each edge oData is FE, FD, FB, F7, EF, DF, BF, 7F in turn, with 1-cycle latency.
- Disable combinations: iData=3'b101 with iEna=00, 01, 11 -> oData=8'hFF each time; with iEna=10 -> 8'hDF.
- Reset mid-stream: while enabled with iData=3'b110 (oData=8'hBF), pull iRst_n low for 1 edge -> oData=8'hFF; release -> next edge gives 8'hBF.
- Latency and one-cold check: change iData every cycle at random with iEna=10 -> oData always equals ~(1<<iData from the previous edge), and exactly one bit of oData is 0.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared widths and constants for the 3-to-8 active-low decoder.
// Optional oValid output on the top is controlled by DECODER_VALID_OUT_EN.
package decoder_pkg;

  localparam int unsigned SEL_W = 3;
  localparam int unsigned OUT_W = 8;

  // All lines inactive (active-low outputs).
  localparam logic [OUT_W-1:0] OUT_IDLE = 8'hFF;

  // {G1, G2}: G1 must be high and G2 low to enable decoding.
  localparam logic [1:0] ENA_ACTIVE = 2'b10;

endpackage : decoder_pkg

// File: rtl/decoder_core.sv
// Combinational one-cold decoder: with en high exactly one y_n line is low.
// No state, no clock; the registered wrapper lives in decoder_3to8.
module decoder_core
  import decoder_pkg::*;
#(
  parameter int unsigned SW = SEL_W
) (
  input  logic [SW-1:0]      sel,
  input  logic               en,
  output logic [(1<<SW)-1:0] y_n
);

  localparam int unsigned OW = 1 << SW;

  always_comb begin
    y_n = '1;
    for (int i = 0; i < OW; i++) begin
      if (en && (sel == SW'(i))) begin
        y_n[i] = 1'b0;
      end
    end
  end

endmodule : decoder_core

// File: rtl/decoder_3to8.sv
// 74x138-style decoder with a registered active-low output (1-cycle latency).
// Build with DECODER_VALID_OUT_EN defined to add the registered oValid output.
module decoder_3to8 #(
  parameter int unsigned            SEL_W   = decoder_pkg::SEL_W,
  parameter logic [(2**SEL_W)-1:0]  RST_OUT = decoder_pkg::OUT_IDLE
) (
  input  logic                    iClk,
  input  logic                    iRst_n,
  input  logic [SEL_W-1:0]        iData,
  input  logic [1:0]              iEna,
  output logic [(2**SEL_W)-1:0]   oData
`ifdef DECODER_VALID_OUT_EN
  ,
  output logic                    oValid
`endif
);

  localparam int unsigned OUT_W = 2**SEL_W;

  // No handshake: a new select/enable pair is sampled on every rising edge
  // and its decode appears on oData after that same edge.
  logic             en;
  logic [OUT_W-1:0] data_d;
  logic [OUT_W-1:0] data_q;

  assign en = (iEna == decoder_pkg::ENA_ACTIVE);

  decoder_core #(
    .SW (SEL_W)
  ) u_core (
    .sel (iData),
    .en  (en),
    .y_n (data_d)
  );

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      data_q <= RST_OUT;
    end else begin
      data_q <= data_d;
    end
  end

  assign oData = data_q;

`ifdef DECODER_VALID_OUT_EN
  logic valid_d;
  logic valid_q;

  assign valid_d = en;

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign oValid = valid_q;
`endif

endmodule : decoder_3to8

// File: tb/tb_decoder_3to8.sv
// Self-checking bench for decoder_3to8: directed boundaries plus random stimulus
// against an arithmetic reference model; checks oValid when DECODER_VALID_OUT_EN is set.
module tb_decoder_3to8;

  logic       iClk;
  logic       iRst_n;
  logic [2:0] iData;
  logic [1:0] iEna;
  logic [7:0] oData;
`ifdef DECODER_VALID_OUT_EN
  logic       oValid;
`endif

  int n_vec;
  int n_err;

  logic [7:0] exp_q[$];
  logic       vld_q[$];

  decoder_3to8 dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iData  (iData),
    .iEna   (iEna),
    .oData  (oData)
`ifdef DECODER_VALID_OUT_EN
    ,
    .oValid (oValid)
`endif
  );

  // clock / reset
  initial iClk = 1'b0;
  always #20 iClk = ~iClk;

  // reference model: Y_n = 255 - 2**D when G1 high and G2 low, else all high
  function automatic logic [7:0] ref_out(input logic rst_n, input logic [1:0] ena,
                                         input logic [2:0] d);
    int v;
    if (!rst_n) v = 255;
    else if (ena[1] == 1'b1 && ena[0] == 1'b0) v = 255 - (2 ** int'(d));
    else v = 255;
    return v[7:0];
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // driver: set inputs mid-cycle, clock once, then score one cycle later
  task automatic apply(input string tag, input logic rst_n, input logic [1:0] ena,
                       input logic [2:0] d);
    logic [7:0] e;
    logic       ev;
    @(negedge iClk);
    iRst_n = rst_n;
    iEna   = ena;
    iData  = d;
    exp_q.push_back(ref_out(rst_n, ena, d));
    vld_q.push_back(rst_n && ena == 2'b10);
    @(posedge iClk);
    #1;
    e  = exp_q.pop_front();
    ev = vld_q.pop_front();
    check(tag, oData, e);
    check({tag, "_zeros"}, 8'($countones(~oData)), ev ? 8'd1 : 8'd0);
`ifdef DECODER_VALID_OUT_EN
    check({tag, "_valid"}, {7'd0, oValid}, {7'd0, ev});
`else
    if (ev == 1'b0) ev = 1'b0;
`endif
  endtask

  initial begin
    iRst_n = 1'b0;
    iEna   = 2'b10;
    iData  = 3'b011;
    n_vec  = 0;
    n_err  = 0;

    // reset held two edges with an enabling input pattern
    apply("reset0", 1'b0, 2'b10, 3'b011);
    apply("reset1", 1'b0, 2'b10, 3'b011);

    // full sweep with fixed expected constants
    for (int i = 0; i < 8; i++) begin
      logic [7:0] tbl [8];
      tbl = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
      apply("sweep", 1'b1, 2'b10, 3'(i));
      check("sweep_tbl", oData, tbl[i]);
    end

    // disabling enable combinations, then enabled
    apply("dis00", 1'b1, 2'b00, 3'b101);
    check("dis00_c", oData, 8'hFF);
    apply("dis01", 1'b1, 2'b01, 3'b101);
    check("dis01_c", oData, 8'hFF);
    apply("dis11", 1'b1, 2'b11, 3'b101);
    check("dis11_c", oData, 8'hFF);
    apply("ena10", 1'b1, 2'b10, 3'b101);
    check("ena10_c", oData, 8'hDF);

    // enable dropped mid-stream
    apply("pre_drop", 1'b1, 2'b10, 3'b000);
    apply("drop", 1'b1, 2'b00, 3'b000);
    check("drop_c", oData, 8'hFF);

    // reset mid-stream and recovery
    apply("mid_run", 1'b1, 2'b10, 3'b110);
    check("mid_run_c", oData, 8'hBF);
    apply("mid_rst", 1'b0, 2'b10, 3'b110);
    check("mid_rst_c", oData, 8'hFF);
    apply("mid_rel", 1'b1, 2'b10, 3'b110);
    check("mid_rel_c", oData, 8'hBF);

    // random codes, always enabled
    for (int i = 0; i < 200; i++) begin
      apply("rand_en", 1'b1, 2'b10, 3'($urandom_range(0, 7)));
    end

    // random codes, enables and occasional reset
    for (int i = 0; i < 200; i++) begin
      apply("rand_mix", ($urandom_range(0, 15) != 0), 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_decoder_3to8
